// File: rtl/ifetch_rsp.sv
// Responder end of the IFU fetch interface: grants fetch slots, issues I-mem reads
// and buffers returned lines in an in-order FIFO toward the IDU, with jump flush.
module ifetch_rsp #(
    parameter int unsigned PC_WIDTH   = 30,
    parameter int unsigned LINE_WIDTH = 128,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  i_Clk,
    input  logic                  i_RstN,
    input  logic                  i_FetchV,
    input  logic [PC_WIDTH-3:0]   i_FetchA,
    input  logic [1:0]            i_InstrSel,
    output logic                  o_FetchR,
    output logic                  o_MemRdV,
    output logic [PC_WIDTH-3:0]   o_MemRdA,
    input  logic [LINE_WIDTH-1:0] i_MemRdD,
    input  logic                  i_Flush,
    output logic                  o_RspV,
    output logic [LINE_WIDTH-1:0] o_RspD,
    output logic [1:0]            o_RspSel,
    input  logic                  i_RspR
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 2;

    logic [CNT_W-1:0]      r_Cnt;
    logic [CNT_W-1:0]      r_Inflight;
    logic [PTR_W-1:0]      r_WrPtr;
    logic [PTR_W-1:0]      r_RdPtr;
    logic                  r_Granted;
    logic [MEM_LAT-1:0]    r_PipeV;
    logic [1:0]            r_PipeSel [MEM_LAT];
    logic [LINE_WIDTH-1:0] r_MemD    [DEPTH];
    logic [1:0]            r_MemSel  [DEPTH];

    logic acc;
    logic push;
    logic pop;
    logic credit;

    // Credit counts buffered, in-flight and reserved slots; same-cycle pops are not credited.
    always_comb begin
        acc      = i_FetchV & r_Granted & ~i_Flush;
        push     = r_PipeV[MEM_LAT-1];
        o_RspV   = (r_Cnt != '0) & ~i_Flush;
        pop      = o_RspV & i_RspR;
        credit   = (SUM_W'(r_Cnt) + SUM_W'(r_Inflight) + SUM_W'(r_Granted)) < SUM_W'(DEPTH);
        o_FetchR = i_RstN & ~i_Flush & credit;
        o_MemRdV = acc;
        o_MemRdA = acc ? i_FetchA : '0;
        o_RspD   = r_MemD[r_RdPtr];
        o_RspSel = r_MemSel[r_RdPtr];
    end

    // Control state; a flush drops everything in flight and buffered.
    always_ff @(posedge i_Clk or negedge i_RstN) begin
        if (!i_RstN) begin
            r_Cnt      <= '0;
            r_Inflight <= '0;
            r_WrPtr    <= '0;
            r_RdPtr    <= '0;
            r_Granted  <= 1'b0;
            r_PipeV    <= '0;
        end else if (i_Flush) begin
            r_Cnt      <= '0;
            r_RdPtr    <= r_WrPtr;
            r_Inflight <= '0;
            r_Granted  <= 1'b0;
            r_PipeV    <= '0;
        end else begin
            r_Granted  <= o_FetchR;
            r_PipeV[0] <= acc;
            for (int i = 1; i < MEM_LAT; i++) begin
                r_PipeV[i] <= r_PipeV[i-1];
            end
            r_Inflight <= r_Inflight + CNT_W'(acc) - CNT_W'(push);
            if (push) begin
                r_WrPtr <= r_WrPtr + PTR_W'(1);
            end
            if (pop) begin
                r_RdPtr <= r_RdPtr + PTR_W'(1);
            end
            if (push && !pop) begin
                r_Cnt <= r_Cnt + CNT_W'(1);
            end else if (pop && !push) begin
                r_Cnt <= r_Cnt - CNT_W'(1);
            end
        end
    end

    // InstrSel travels alongside the read; the line is captured when its valid bit reaches the tail.
    always_ff @(posedge i_Clk or negedge i_RstN) begin
        if (!i_RstN) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                r_PipeSel[i] <= '0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                r_MemD[i]   <= '0;
                r_MemSel[i] <= '0;
            end
        end else begin
            r_PipeSel[0] <= i_InstrSel;
            for (int i = 1; i < MEM_LAT; i++) begin
                r_PipeSel[i] <= r_PipeSel[i-1];
            end
            if (push && !i_Flush) begin
                r_MemD[r_WrPtr]   <= i_MemRdD;
                r_MemSel[r_WrPtr] <= r_PipeSel[MEM_LAT-1];
            end
        end
    end
endmodule

// File: tb/tb_ifetch_rsp.sv
// Directed bench for ifetch_rsp: IFU and fixed-latency I-mem models around the
// responder, with an expected-response queue checked at every pop.
module tb_ifetch_rsp;
    localparam int unsigned AW  = 28;
    localparam int unsigned LW  = 128;
    localparam int unsigned LAT = 2;

    logic          clk = 1'b0;
    logic          rstN;
    logic          fetchV, fetchR, memRdV, flush, rspV, rspR;
    logic [AW-1:0] fetchA, memRdA;
    logic [1:0]    sel, rspSel;
    logic [LW-1:0] memD, rspD;

    always #5 clk = ~clk;

    ifetch_rsp dut (
        .i_Clk(clk), .i_RstN(rstN), .i_FetchV(fetchV), .i_FetchA(fetchA),
        .i_InstrSel(sel), .o_FetchR(fetchR), .o_MemRdV(memRdV), .o_MemRdA(memRdA),
        .i_MemRdD(memD), .i_Flush(flush), .o_RspV(rspV), .o_RspD(rspD),
        .o_RspSel(rspSel), .i_RspR(rspR)
    );

    function automatic logic [LW-1:0] memf(input logic [AW-1:0] a);
        return {4{4'hC, a}};
    endfunction

    // Fixed-latency memory: returns the line for the address read LAT cycles earlier.
    logic [LAT-1:0] mV = '0;
    logic [AW-1:0]  mA [LAT];
    always @(posedge clk) begin
        mV    <= {mV[LAT-2:0], memRdV};
        mA[0] <= memRdA;
        for (int i = 1; i < LAT; i++) mA[i] <= mA[i-1];
    end
    assign memD = mV[LAT-1] ? memf(mA[LAT-1]) : {LW{1'b1}};

    int            nCmp = 0;
    int            nErr = 0;
    logic [LW-1:0] expD[$];
    logic [1:0]    expS[$];
    bit            ifuOn = 0;
    int            toIssue = 0;
    int            k = 0;
    int            nReads;
    logic [AW-1:0] nextA;
    logic          prevR;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; in IFU mode fetch whenever the previous cycle granted.
    task automatic tick();
        @(negedge clk) prevR = fetchR;
        @(posedge clk) #1;
        if (ifuOn) begin
            fetchV = prevR && (toIssue > 0);
            if (fetchV) begin
                fetchA = nextA;
                sel    = 2'(k);
                expD.push_back(memf(nextA));
                expS.push_back(2'(k));
                nextA++;
                k++;
                toIssue--;
            end
        end
    endtask

    task automatic pop_chk(input string tag);
        if (rspV && rspR) begin
            chk({tag, "_expected"}, LW'(expD.size() != 0), LW'(1));
            if (expD.size() != 0) begin
                chk({tag, "_data"}, rspD, expD.pop_front());
                chk({tag, "_sel"}, LW'(rspSel), LW'(expS.pop_front()));
            end
        end
    endtask

    task automatic cyc(input string tag, input logic r);
        tick();
        rspR = r;
        #2;
        pop_chk(tag);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        rstN = 1'b0; fetchV = 0; fetchA = '0; sel = '0; flush = 0; rspR = 0;
        #12;
        chk("rst_fetchR", LW'(fetchR), 0);
        chk("rst_memRdV", LW'(memRdV), 0);
        chk("rst_memRdA", LW'(memRdA), 0);
        chk("rst_rspV",   LW'(rspV), 0);
        chk("rst_rspD",   rspD, 0);
        chk("rst_rspSel", LW'(rspSel), 0);
        @(posedge clk) #1 rstN = 1'b1;
        #2 chk("rst_fetchR_after", LW'(fetchR), 1);

        // Single fetch: response three cycles after acceptance
        tick(); fetchV = 1; fetchA = 28'h10; sel = 2; #2;
        chk("t1_memRdV", LW'(memRdV), 1);
        chk("t1_memRdA", LW'(memRdA), LW'(28'h10));
        tick(); fetchV = 0; #2 chk("t1_rspV_c2", LW'(rspV), 0);
        tick(); #2 chk("t1_rspV_c3", LW'(rspV), 0);
        tick(); rspR = 1; #2;
        chk("t1_rspV", LW'(rspV), 1);
        chk("t1_rspD", rspD, memf(28'h10));
        chk("t1_rspSel", LW'(rspSel), 2);
        tick(); rspR = 0; #2 chk("t1_rspV_after", LW'(rspV), 0);

        // Stream of 8 fetches, IDU always ready
        ifuOn = 1; toIssue = 8; nextA = 28'h100; k = 0;
        for (int i = 0; i < 20; i++) cyc("t2", 1'b1);
        chk("t2_all_returned", LW'(expD.size()), 0);
        chk("t2_issued", LW'(toIssue), 0);

        // IDU stalled: credits stop at DEPTH reads
        toIssue = 10; nextA = 28'h200; nReads = 0;
        for (int i = 0; i < 10; i++) begin
            cyc("t3", 1'b0);
            if (memRdV) nReads++;
        end
        chk("t3_reads", LW'(nReads), 4);
        chk("t3_fetchR_closed", LW'(fetchR), 0);
        chk("t3_rspV_full", LW'(rspV), 1);
        chk("t3_head_hold", rspD, memf(28'h200));
        ifuOn = 0; fetchV = 0;
        cyc("t3_pulse", 1'b1);
        tick(); rspR = 0; #2 chk("t3_fetchR_reopen", LW'(fetchR), 1);
        for (int i = 0; i < 6; i++) cyc("t3_drain", 1'b1);
        chk("t3_no_loss", LW'(expD.size()), 0);
        chk("t3_empty", LW'(rspV), 0);
        rspR = 0;

        // Flush with one line buffered and two reads in flight
        tick(); fetchV = 1; fetchA = 28'h300; sel = 0; #2 chk("t4_acc0", LW'(memRdV), 1);
        tick(); fetchA = 28'h301; sel = 1; #2 chk("t4_acc1", LW'(memRdV), 1);
        tick(); fetchA = 28'h302; sel = 2; #2 chk("t4_acc2", LW'(memRdV), 1);
        tick(); fetchV = 0; flush = 1; #2;
        chk("t4_flush_rspV", LW'(rspV), 0);
        chk("t4_flush_fetchR", LW'(fetchR), 0);
        tick(); flush = 0; fetchV = 1; fetchA = 28'h3FF; sel = 3; #2;
        chk("t4_fetchR_after", LW'(fetchR), 1);
        chk("t5_ungranted_memRdV", LW'(memRdV), 0);
        chk("t5_ungranted_memRdA", LW'(memRdA), 0);
        chk("t4_late_rspV_e", LW'(rspV), 0);
        tick(); fetchA = 28'h310; sel = 1; #2;
        chk("t4_new_memRdV", LW'(memRdV), 1);
        chk("t4_new_memRdA", LW'(memRdA), LW'(28'h310));
        chk("t4_late_rspV_f", LW'(rspV), 0);
        tick(); fetchV = 0; #2 chk("t4_late_rspV_g", LW'(rspV), 0);
        tick(); #2 chk("t4_late_rspV_h", LW'(rspV), 0);
        tick(); rspR = 1; #2;
        chk("t4_new_rspV", LW'(rspV), 1);
        chk("t4_new_rspD", rspD, memf(28'h310));
        chk("t4_new_rspSel", LW'(rspSel), 1);
        tick(); rspR = 0; #2 chk("t4_only_own", LW'(rspV), 0);

        // Reset mid-stream
        ifuOn = 1; toIssue = 6; nextA = 28'h400; k = 0;
        for (int i = 0; i < 5; i++) cyc("t5_pre", 1'b0);
        ifuOn = 0; fetchV = 1;
        @(posedge clk) #1 rstN = 1'b0;
        #1;
        chk("t5_rst_fetchR", LW'(fetchR), 0);
        chk("t5_rst_memRdV", LW'(memRdV), 0);
        chk("t5_rst_memRdA", LW'(memRdA), 0);
        chk("t5_rst_rspV", LW'(rspV), 0);
        chk("t5_rst_rspD", rspD, 0);
        chk("t5_rst_rspSel", LW'(rspSel), 0);
        expD.delete(); expS.delete();
        @(posedge clk) #1 rstN = 1'b1; fetchV = 0;
        #2 chk("t5_fetchR_after", LW'(fetchR), 1);

        // Mixed push/pop across several pointer wraps
        ifuOn = 1; toIssue = 16; nextA = 28'h500; k = 0;
        for (int i = 0; i < 40; i++) cyc("t6", (i % 3) != 0);
        ifuOn = 0; fetchV = 0;
        for (int i = 0; i < 8; i++) cyc("t6_drain", 1'b1);
        chk("t6_issued", LW'(toIssue), 0);
        chk("t6_no_loss", LW'(expD.size()), 0);
        chk("t6_empty", LW'(rspV), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule
